mdl_bubdeser: RTL and testbench

- Downstream consumer of the bubble read front-end's serial stream (BDI / BDI_EN).
- Hunts for a sync byte, then deserialises the bit stream MSB-first into bytes. Each byte is presented with an address and a one-cycle valid pulse to the page buffer.
- Signals page completion after PAGE_BYTES bytes and aborts cleanly if the input enable drops mid-page.

---
 rtl/bubdeser_pkg.sv | 20 ++
 rtl/mdl_bubcrc16.sv | 44 ++++
 rtl/mdl_bubdeser.sv | 184 ++++++++++++++++++
 tb/tb_mdl_bubdeser.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bubdeser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bubdeser_pkg : shared types and constants for the bubble deserialiser |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bubdeser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY          = 16'h1021;
  localparam logic [15:0] CRC_INIT          = 16'hFFFF;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h55;

endpackage
`default_nettype wire

// File: rtl/mdl_bubcrc16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdl_bubcrc16 : bit-serial CRC-16-CCITT, MSB-first, with look-ahead    |
// |                residue-zero flag for the bit being presented now     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdl_bubcrc16
  import bubdeser_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_init,
  input  logic i_en,
  input  logic i_bit,
  output logic o_next_zero
);

  logic [15:0] r_crc_q;
  logic [15:0] w_crc_d;
  logic [15:0] w_crc_step;

  always_comb begin
    w_crc_step = {r_crc_q[14:0], 1'b0} ^ ((r_crc_q[15] ^ i_bit) ? CRC_POLY : 16'h0000);
    w_crc_d    = r_crc_q;
    if (i_init) begin
      w_crc_d = CRC_INIT;
    end else if (i_en) begin
      w_crc_d = w_crc_step;
    end
  end

  // Lets the caller judge the residue on the same edge that accepts the last bit.
  assign o_next_zero = (w_crc_step == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc_q <= CRC_INIT;
    end else begin
      r_crc_q <= w_crc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdl_bubdeser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdl_bubdeser : sync-hunting MSB-first byte deserialiser for the       |
// |                bubble read stream. CRC check under MDL_BUBDESER_CRC_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdl_bubdeser
  import bubdeser_pkg::*;
#(
  parameter int          PAGE_BYTES = 130,
  parameter int          ADDR_W     = 8,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST,
  input  logic              i_CLK2M_PCEN_n,
  input  logic              i_BITSTB_n,
  input  logic              i_BDI,
  input  logic              i_BDI_EN,
  input  logic              i_PAGE_START,
  output logic [7:0]        o_BYTE,
  output logic              o_BYTE_VLD,
  output logic [ADDR_W-1:0] o_BYTE_ADDR,
  output logic              o_PAGE_DONE,
  output logic              o_ABORT,
  output logic              o_CRC_ERR,
  output logic              o_BUSY
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(PAGE_BYTES - 1);

  state_e            r_state_q, w_state_d;
  logic [6:0]        r_sr_q, w_sr_d;
  logic [2:0]        r_bitcnt_q, w_bitcnt_d;
  logic [ADDR_W-1:0] r_addr_q, w_addr_d;
  logic [7:0]        r_byte_q, w_byte_d;
  logic              r_vld_q, w_vld_d;
  logic [ADDR_W-1:0] r_byte_addr_q, w_byte_addr_d;
  logic              r_done_q, w_done_d;
  logic              r_abort_q, w_abort_d;

  logic              w_acc;
  logic              w_drop;
  logic [7:0]        w_shift;
  logic              w_last_bit;
  logic              w_final;

  // Only seven history bits are stored; the eighth is always the live i_BDI.
  assign w_shift    = {r_sr_q, i_BDI};
  assign w_acc      = ~i_CLK2M_PCEN_n & ~i_BITSTB_n & i_BDI_EN;
  assign w_drop     = ~i_CLK2M_PCEN_n & ~i_BDI_EN;
  assign w_last_bit = w_acc & ~i_PAGE_START & (r_state_q == ST_COLLECT) & (r_bitcnt_q == 3'd7);
  assign w_final    = w_last_bit & (r_addr_q == c_LAST_ADDR);

  always_comb begin
    w_state_d     = r_state_q;
    w_sr_d        = r_sr_q;
    w_bitcnt_d    = r_bitcnt_q;
    w_addr_d      = r_addr_q;
    w_byte_d      = r_byte_q;
    w_vld_d       = 1'b0;
    w_byte_addr_d = r_byte_addr_q;
    w_done_d      = r_done_q;
    w_abort_d     = 1'b0;

    if (i_PAGE_START) begin
      w_state_d  = ST_HUNT;
      w_sr_d     = 7'd0;
      w_bitcnt_d = 3'd0;
      w_addr_d   = '0;
      w_done_d   = 1'b0;
    end else begin
      case (r_state_q)
        ST_HUNT: begin
          if (w_drop) begin
            w_state_d = ST_IDLE;
            w_abort_d = 1'b1;
          end else if (w_acc) begin
            w_sr_d = w_shift[6:0];
            if (w_shift == SYNC_BYTE) begin
              w_state_d  = ST_COLLECT;
              w_bitcnt_d = 3'd0;
              w_addr_d   = '0;
            end
          end
        end
        ST_COLLECT: begin
          if (w_drop) begin
            w_state_d = ST_IDLE;
            w_abort_d = 1'b1;
          end else if (w_acc) begin
            w_sr_d     = w_shift[6:0];
            w_bitcnt_d = r_bitcnt_q + 3'd1;
            if (w_last_bit) begin
              w_byte_d      = w_shift;
              w_vld_d       = 1'b1;
              w_byte_addr_d = r_addr_q;
              if (w_final) begin
                w_state_d = ST_DONE;
                w_done_d  = 1'b1;
              end else begin
                w_addr_d = r_addr_q + ADDR_W'(1);
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      r_state_q     <= ST_IDLE;
      r_sr_q        <= 7'd0;
      r_bitcnt_q    <= 3'd0;
      r_addr_q      <= '0;
      r_byte_q      <= 8'd0;
      r_vld_q       <= 1'b0;
      r_byte_addr_q <= '0;
      r_done_q      <= 1'b0;
      r_abort_q     <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_sr_q        <= w_sr_d;
      r_bitcnt_q    <= w_bitcnt_d;
      r_addr_q      <= w_addr_d;
      r_byte_q      <= w_byte_d;
      r_vld_q       <= w_vld_d;
      r_byte_addr_q <= w_byte_addr_d;
      r_done_q      <= w_done_d;
      r_abort_q     <= w_abort_d;
    end
  end

`ifdef MDL_BUBDESER_CRC_EN
  logic w_crc_init;
  logic w_crc_en;
  logic w_crc_zero;
  logic r_crc_err_q, w_crc_err_d;

  // Held at init throughout HUNT so COLLECT always starts from a fresh value.
  assign w_crc_init = i_PAGE_START | (r_state_q == ST_HUNT);
  assign w_crc_en   = w_acc & (r_state_q == ST_COLLECT);

  mdl_bubcrc16 u_crc (
    .clk         (i_MCLK),
    .rst         (i_SYS_RST),
    .i_init      (w_crc_init),
    .i_en        (w_crc_en),
    .i_bit       (i_BDI),
    .o_next_zero (w_crc_zero)
  );

  always_comb begin
    w_crc_err_d = r_crc_err_q;
    if (w_final) begin
      w_crc_err_d = ~w_crc_zero;
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      r_crc_err_q <= 1'b0;
    end else begin
      r_crc_err_q <= w_crc_err_d;
    end
  end

  assign o_CRC_ERR = r_crc_err_q;
`else
  assign o_CRC_ERR = 1'b0;
`endif

  assign o_BYTE      = r_byte_q;
  assign o_BYTE_VLD  = r_vld_q;
  assign o_BYTE_ADDR = r_byte_addr_q;
  assign o_PAGE_DONE = r_done_q;
  assign o_ABORT     = r_abort_q;
  assign o_BUSY      = (r_state_q == ST_HUNT) || (r_state_q == ST_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_mdl_bubdeser.sv
`default_nettype none
// Bench for mdl_bubdeser: directed vector table, hand sequences for page
// completion / abort / restart, then random traffic against a stream-level model.
module tb_mdl_bubdeser;

  localparam int         PB   = 4;
  localparam int         AW   = 8;
  localparam logic [7:0] SYNC = 8'h55;

  logic          i_MCLK = 1'b0;
  logic          i_SYS_RST;
  logic          i_CLK2M_PCEN_n;
  logic          i_BITSTB_n;
  logic          i_BDI;
  logic          i_BDI_EN;
  logic          i_PAGE_START;
  logic [7:0]    o_BYTE;
  logic          o_BYTE_VLD;
  logic [AW-1:0] o_BYTE_ADDR;
  logic          o_PAGE_DONE;
  logic          o_ABORT;
  logic          o_CRC_ERR;
  logic          o_BUSY;

  mdl_bubdeser #(.PAGE_BYTES(PB), .ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
    .i_MCLK         (i_MCLK),
    .i_SYS_RST      (i_SYS_RST),
    .i_CLK2M_PCEN_n (i_CLK2M_PCEN_n),
    .i_BITSTB_n     (i_BITSTB_n),
    .i_BDI          (i_BDI),
    .i_BDI_EN       (i_BDI_EN),
    .i_PAGE_START   (i_PAGE_START),
    .o_BYTE         (o_BYTE),
    .o_BYTE_VLD     (o_BYTE_VLD),
    .o_BYTE_ADDR    (o_BYTE_ADDR),
    .o_PAGE_DONE    (o_PAGE_DONE),
    .o_ABORT        (o_ABORT),
    .o_CRC_ERR      (o_CRC_ERR),
    .o_BUSY         (o_BUSY)
  );

  always #5 i_MCLK = ~i_MCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream-level reference: modes 0 idle, 1 hunting, 2 collecting, 3 page complete.
  int         m_mode;
  int         m_win;
  int         m_nb;
  int         m_cur;
  int         m_page[$];
  logic       m_vld, m_abort, m_done, m_crcerr;
  logic [7:0] m_byte;
  logic [7:0] m_addr;

  function automatic logic [15:0] crc_bytes(input int q[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (q[k]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ q[k][j];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_win = 0; m_nb = 0; m_cur = 0; m_page.delete();
    m_vld = 0; m_abort = 0; m_done = 0; m_crcerr = 0; m_byte = 0; m_addr = 0;
  endtask

  task automatic model_step(input bit pc, input bit st, input bit b, input bit en, input bit sp);
    bit acc;
    acc     = !pc && !st && en;
    m_vld   = 0;
    m_abort = 0;
    if (sp) begin
      m_mode = 1; m_win = 0; m_done = 0; m_page.delete();
    end else if (m_mode == 1 || m_mode == 2) begin
      if (!pc && !en) begin
        m_mode  = 0;
        m_abort = 1;
      end else if (acc && m_mode == 1) begin
        m_win = ((m_win << 1) | int'(b)) & 255;
        if (m_win == int'(SYNC)) begin
          m_mode = 2; m_nb = 0; m_cur = 0;
        end
      end else if (acc) begin
        m_cur = (m_cur << 1) | int'(b);
        m_nb++;
        if (m_nb == 8) begin
          m_vld  = 1;
          m_byte = m_cur[7:0];
          m_addr = 8'(m_page.size());
          m_page.push_back(m_cur);
          m_nb = 0; m_cur = 0;
          if (m_page.size() == PB) begin
            m_mode   = 3;
            m_done   = 1;
            m_crcerr = (crc_bytes(m_page) != 16'h0000);
          end
        end
      end
    end
  endtask

  task automatic model_compare();
    chk("m_vld",   o_BYTE_VLD,  m_vld);
    chk("m_byte",  o_BYTE,      m_byte);
    chk("m_addr",  o_BYTE_ADDR, m_addr);
    chk("m_done",  o_PAGE_DONE, m_done);
    chk("m_abort", o_ABORT,     m_abort);
    chk("m_busy",  o_BUSY,      (m_mode == 1 || m_mode == 2));
`ifdef MDL_BUBDESER_CRC_EN
    if (m_done) chk("m_crcerr", o_CRC_ERR, m_crcerr);
`else
    chk("m_crcerr", o_CRC_ERR, 1'b0);
`endif
  endtask

  task automatic step(input bit pc, input bit st, input bit b, input bit en, input bit sp);
    i_CLK2M_PCEN_n = pc;
    i_BITSTB_n     = st;
    i_BDI          = b;
    i_BDI_EN       = en;
    i_PAGE_START   = sp;
    model_step(pc, st, b, en, sp);
    @(posedge i_MCLK);
    #1;
    model_compare();
  endtask

  task automatic send_bit(input bit b);
    step(1'b0, 1'b0, b, 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int j = 7; j >= 0; j--) send_bit(v[j]);
  endtask

  typedef struct {
    bit         pc, st, b, en, sp;
    bit         ev;
    logic [7:0] eb;
    logic [7:0] ea;
    bit         ebusy, edone, eab;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit pc, input bit st, input bit b, input bit en, input bit sp,
                     input bit ev, input logic [7:0] eb, input logic [7:0] ea,
                     input bit ebusy, input bit edone, input bit eab);
    vec_t v;
    v.pc = pc; v.st = st; v.b = b; v.en = en; v.sp = sp;
    v.ev = ev; v.eb = eb; v.ea = ea; v.ebusy = ebusy; v.edone = edone; v.eab = eab;
    tbl.push_back(v);
  endtask

  bit src[$];

  task automatic refill();
    int          q[$];
    logic [15:0] c;
    logic [7:0]  bv;
    if ($urandom_range(0, 1) == 0) begin
      for (int j = 7; j >= 0; j--) src.push_back(SYNC[j]);
`ifdef MDL_BUBDESER_CRC_EN
      for (int k = 0; k < PB - 2; k++) q.push_back(int'($urandom_range(0, 255)));
      c = crc_bytes(q);
      q.push_back(int'(c[15:8]));
      q.push_back(int'(c[7:0]));
      if ($urandom_range(0, 3) == 0) q[0] = q[0] ^ 1;
`else
      c = 16'h0000;
      for (int k = 0; k < PB; k++) q.push_back(int'($urandom_range(0, 255)));
`endif
      foreach (q[k]) begin
        bv = q[k][7:0];
        for (int j = 7; j >= 0; j--) src.push_back(bv[j]);
      end
    end else begin
      for (int j = 0; j < 8; j++) src.push_back(bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_random(input int n);
    bit pc, st, en, sp, b;
    for (int i = 0; i < n; i++) begin
      pc = ($urandom_range(0, 9) < 3);
      st = ($urandom_range(0, 9) < 4);
      en = ($urandom_range(0, 199) != 0);
      sp = 1'b0;
      if ((m_mode == 0 || m_mode == 3) && $urandom_range(0, 19) == 0) sp = 1'b1;
      else if ($urandom_range(0, 999) == 0) sp = 1'b1;
      if (src.size() == 0) refill();
      b = src[0];
      if (!pc && !st && en) void'(src.pop_front());
      step(pc, st, b, en, sp);
    end
  endtask

  initial begin
    logic [10:0] pre;
    logic [7:0]  dat;
    logic [15:0] c;
    int          q[$];

    i_SYS_RST = 1'b1; i_CLK2M_PCEN_n = 1'b1; i_BITSTB_n = 1'b1;
    i_BDI = 1'b0; i_BDI_EN = 1'b0; i_PAGE_START = 1'b0;
    model_reset();
    repeat (3) @(posedge i_MCLK);
    #1;
    chk("rst_vld",   o_BYTE_VLD,  1'b0);
    chk("rst_byte",  o_BYTE,      8'h00);
    chk("rst_addr",  o_BYTE_ADDR, 8'h00);
    chk("rst_done",  o_PAGE_DONE, 1'b0);
    chk("rst_abort", o_ABORT,     1'b0);
    chk("rst_crc",   o_CRC_ERR,   1'b0);
    chk("rst_busy",  o_BUSY,      1'b0);
    i_SYS_RST = 1'b0;

    // Sync hunt with a misaligned lead-in, then 0xA3 with stalls around every bit.
    pre = 11'b011_0101_0101;
    dat = 8'hA3;
    add(0, 1, 0, 1, 1,  0, 8'h00, 8'h00, 1, 0, 0);
    for (int j = 10; j >= 0; j--) add(0, 0, pre[j], 1, 0,  0, 8'h00, 8'h00, 1, 0, 0);
    for (int j = 7; j >= 0; j--) begin
      add(1, 0, ~dat[j], 1, 0,  0, 8'h00, 8'h00, 1, 0, 0);
      add(0, 1, ~dat[j], 1, 0,  0, 8'h00, 8'h00, 1, 0, 0);
      add(1, 1, ~dat[j], 0, 0,  0, 8'h00, 8'h00, 1, 0, 0);
      add(0, 0, dat[j], 1, 0,  (j == 0), (j == 0) ? 8'hA3 : 8'h00, 8'h00, 1, 0, 0);
    end
    add(0, 1, 0, 1, 0,  0, 8'hA3, 8'h00, 1, 0, 0);
    foreach (tbl[k]) begin
      step(tbl[k].pc, tbl[k].st, tbl[k].b, tbl[k].en, tbl[k].sp);
      chk($sformatf("t%0d_vld",   k), o_BYTE_VLD,  tbl[k].ev);
      chk($sformatf("t%0d_byte",  k), o_BYTE,      tbl[k].eb);
      chk($sformatf("t%0d_addr",  k), o_BYTE_ADDR, tbl[k].ea);
      chk($sformatf("t%0d_busy",  k), o_BUSY,      tbl[k].ebusy);
      chk($sformatf("t%0d_done",  k), o_PAGE_DONE, tbl[k].edone);
      chk($sformatf("t%0d_abort", k), o_ABORT,     tbl[k].eab);
    end

    // Page completion: remaining three bytes, then hold through DONE.
    send_byte(8'h22);
    chk("pg_addr1", o_BYTE_ADDR, 8'd1);
    chk("pg_done1", o_PAGE_DONE, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("pg_vld4",  o_BYTE_VLD,  1'b1);
    chk("pg_byte4", o_BYTE,      8'h44);
    chk("pg_addr4", o_BYTE_ADDR, 8'd3);
    chk("pg_done4", o_PAGE_DONE, 1'b1);
    chk("pg_busy4", o_BUSY,      1'b0);
    step(0, 1, 0, 0, 0);
    chk("pg_hold_done",  o_PAGE_DONE, 1'b1);
    chk("pg_hold_abort", o_ABORT,     1'b0);
    chk("pg_hold_vld",   o_BYTE_VLD,  1'b0);
    step(0, 1, 0, 1, 1);
    chk("pg_clr_done", o_PAGE_DONE, 1'b0);
    chk("pg_clr_busy", o_BUSY,      1'b1);

    // Abort three bits into the third byte; enable low outside PCEN is ignored.
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    step(1, 1, 0, 0, 0);
    chk("ab_gated_abort", o_ABORT, 1'b0);
    chk("ab_gated_busy",  o_BUSY,  1'b1);
    step(0, 1, 0, 0, 0);
    chk("ab_abort", o_ABORT,     1'b1);
    chk("ab_busy",  o_BUSY,      1'b0);
    chk("ab_vld",   o_BYTE_VLD,  1'b0);
    chk("ab_done",  o_PAGE_DONE, 1'b0);
    step(0, 0, 1, 1, 0);
    chk("ab_pulse_end", o_ABORT,     1'b0);
    chk("ab_addr_held", o_BYTE_ADDR, 8'd1);
    chk("ab_idle",      o_BUSY,      1'b0);

    // Restart mid-page, coinciding with an abort condition: restart wins.
    step(0, 1, 0, 1, 1);
    send_byte(SYNC);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    step(0, 1, 0, 0, 1);
    chk("rs_abort", o_ABORT, 1'b0);
    chk("rs_busy",  o_BUSY,  1'b1);
    send_byte(SYNC);
    send_byte(8'hC3);
    chk("rs_vld",  o_BYTE_VLD,  1'b1);
    chk("rs_byte", o_BYTE,      8'hC3);
    chk("rs_addr", o_BYTE_ADDR, 8'd0);

`ifdef MDL_BUBDESER_CRC_EN
    q.delete(); q.push_back(32'h12); q.push_back(32'h34);
    c = crc_bytes(q);
    step(0, 1, 0, 1, 1);
    send_byte(SYNC); send_byte(8'h12); send_byte(8'h34); send_byte(c[15:8]); send_byte(c[7:0]);
    chk("crc_good_done", o_PAGE_DONE, 1'b1);
    chk("crc_good_err",  o_CRC_ERR,   1'b0);
    step(0, 1, 0, 1, 1);
    send_byte(SYNC); send_byte(8'h12); send_byte(8'h35); send_byte(c[15:8]); send_byte(c[7:0]);
    chk("crc_bad_done", o_PAGE_DONE, 1'b1);
    chk("crc_bad_err",  o_CRC_ERR,   1'b1);
`else
    q.delete();
    c = 16'h0000;
    chk("crc_tied", o_CRC_ERR, 1'b0);
`endif

    run_random(20000);

    // Reset mid-activity drops state with no pulses.
    step(0, 1, 0, 1, 1);
    send_byte(SYNC);
    send_bit(1'b1);
    i_SYS_RST = 1'b1;
    @(posedge i_MCLK);
    #1;
    model_reset();
    chk("rr_busy",  o_BUSY,      1'b0);
    chk("rr_abort", o_ABORT,     1'b0);
    chk("rr_vld",   o_BYTE_VLD,  1'b0);
    chk("rr_addr",  o_BYTE_ADDR, 8'd0);
    i_SYS_RST = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
